skew_stream_feeder: RTL



---
 rtl/skew_stream_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/skew_stream_feeder.sv
// Accepts a LANES x DEPTH matrix per handshake and replays it as a diagonally skewed beat stream.
// Two slots (active and pending) let consecutive matrices stream with no bubble between them.
module skew_stream_feeder #(
  parameter int WIDTH = 4,
  parameter int LANES = 3,
  parameter int DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DEPTH*WIDTH-1:0] in_data,
  input  logic                         in_rev,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [LANES-1:0]             out_lane_valid,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         busy
);

  localparam int N  = DEPTH + LANES - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = LANES * DEPTH * WIDTH;
  localparam int OW = LANES * WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  logic          act_full_q, act_full_d;
  logic          pend_full_q, pend_full_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [MW-1:0] act_data_q, act_data_d;
  logic          act_rev_q, act_rev_d;
  logic [MW-1:0] pend_data_q, pend_data_d;
  logic          pend_rev_q, pend_rev_d;

  logic          in_fire;
  logic          out_fire;
  logic [MW-1:0] lane_sh;
  logic [OW-1:0] lane_ext;

  assign in_ready  = !pend_full_q;
  assign in_fire   = in_valid && !pend_full_q;
  assign out_valid = act_full_q;
  assign out_fire  = act_full_q && out_ready;
  assign busy      = act_full_q || pend_full_q;
  assign out_first = act_full_q && (beat_q == '0);
  assign out_last  = act_full_q && (beat_q == LAST_BEAT);

  always_comb begin
    act_full_d  = act_full_q;
    pend_full_d = pend_full_q;
    beat_d      = beat_q;
    act_data_d  = act_data_q;
    act_rev_d   = act_rev_q;
    pend_data_d = pend_data_q;
    pend_rev_d  = pend_rev_q;

    if (out_fire) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        if (pend_full_q) begin
          act_data_d  = pend_data_q;
          act_rev_d   = pend_rev_q;
          pend_full_d = 1'b0;
        end else begin
          act_full_d = 1'b0;
        end
      end else begin
        beat_d = beat_q + CW'(1);
      end
    end

    // An accept only happens with pending empty, so an active slot freed this edge takes it directly.
    if (in_fire) begin
      if (!act_full_d) begin
        act_data_d = in_data;
        act_rev_d  = in_rev;
        act_full_d = 1'b1;
        beat_d     = '0;
      end else begin
        pend_data_d = in_data;
        pend_rev_d  = in_rev;
        pend_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      act_full_q  <= 1'b0;
      pend_full_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      act_full_q  <= act_full_d;
      pend_full_q <= pend_full_d;
      beat_q      <= beat_d;
    end
  end

  always_ff @(posedge clock) begin
    act_data_q  <= act_data_d;
    act_rev_q   <= act_rev_d;
    pend_data_q <= pend_data_d;
    pend_rev_q  <= pend_rev_d;
  end

  // Lane r shows element t-d(r) of its row inside its DEPTH-beat window, zero elsewhere.
  always_comb begin
    out_data       = '0;
    out_lane_valid = '0;
    lane_sh        = '0;
    lane_ext       = '0;
    for (int r = 0; r < LANES; r++) begin
      int dly;
      int t;
      dly = act_rev_q ? (LANES - 1 - r) : r;
      t   = int'(beat_q);
      if (act_full_q && (t >= dly) && (t < dly + DEPTH)) begin
        lane_sh                 = act_data_q >> ((r * DEPTH + t - dly) * WIDTH);
        lane_ext                = '0;
        lane_ext[WIDTH-1:0]     = lane_sh[WIDTH-1:0];
        out_data                = out_data | (lane_ext << (r * WIDTH));
        out_lane_valid          = out_lane_valid | (LANES'(1) << r);
      end
    end
  end

endmodule
